icache_refill_ctrl: RTL and testbench

Instruction-cache refill controller: accepts a miss request, captures the victim way from the cache's one-hot replacement pointer, fetches the full line from memory as a burst of beats, and writes the assembled line into the victim way. After the write it pulses the replacement-pointer update so the next miss targets the next way. It sits between the icache lookup logic, the one-hot replacement register and the memory-side request/response port.

---
 rtl/icache_refill_ctrl.sv | 104 ++++++++++
 tb/tb_icache_refill_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill controller: one miss at a time, burst-fetches the
// line into a staging register, writes it to the victim way, advances replacement.
module icache_refill_ctrl #(
   parameter int N_WAYS     = 2,
   parameter int ADDR_LEN   = 32,
   parameter int BEAT_LEN   = 64,
   parameter int LINE_BEATS = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           miss_valid_i,
   output logic                           miss_ready_o,
   input  logic [ADDR_LEN-1:0]            miss_addr_i,
   input  logic [N_WAYS-1:0]              victim_oh_i,
   output logic                           mem_req_valid_o,
   input  logic                           mem_req_ready_i,
   output logic [ADDR_LEN-1:0]            mem_req_addr_o,
   input  logic                           mem_rsp_valid_i,
   input  logic [BEAT_LEN-1:0]            mem_rsp_data_i,
   output logic                           line_we_o,
   output logic [$clog2(N_WAYS)-1:0]      line_way_o,
   output logic [ADDR_LEN-1:0]            line_addr_o,
   output logic [LINE_BEATS*BEAT_LEN-1:0] line_data_o,
   output logic                           repl_update_o,
   output logic                           onehot_err_o
);

   localparam int OFF = $clog2(LINE_BEATS*BEAT_LEN/8);
   localparam int CW  = $clog2(LINE_BEATS);
   localparam int WW  = $clog2(N_WAYS);
   localparam logic [ADDR_LEN-1:0] ALIGN_MASK = {{(ADDR_LEN-OFF){1'b1}}, {OFF{1'b0}}};

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_REQ   = 2'd1;
   localparam logic [1:0] S_RECV  = 2'd2;
   localparam logic [1:0] S_WRITE = 2'd3;

   logic [1:0]                     r_state;
   logic [ADDR_LEN-1:0]            r_addr;
   logic [WW-1:0]                  r_way;
   logic                           r_err;
   logic [CW-1:0]                  r_cnt;
   logic [LINE_BEATS*BEAT_LEN-1:0] r_line;
   logic [WW-1:0]                  w_way;
   logic                           w_onehot;

   // Malformed pointers fall back to the lowest set bit so a way is always chosen.
   always_comb begin
      w_way = '0;
      for (int i = N_WAYS-1; i >= 0; i--)
         if (victim_oh_i[i]) w_way = WW'(i);
   end

   assign w_onehot = (victim_oh_i != '0) &&
                     ((victim_oh_i & (victim_oh_i - 1'b1)) == '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_way   <= '0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
         r_line  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (miss_valid_i) begin
                  r_addr  <= miss_addr_i & ALIGN_MASK;
                  r_way   <= w_way;
                  r_err   <= r_err | ~w_onehot;
                  r_state <= S_REQ;
               end
            end
            S_REQ: begin
               if (mem_req_ready_i) begin
                  r_cnt   <= '0;
                  r_state <= S_RECV;
               end
            end
            S_RECV: begin
               if (mem_rsp_valid_i) begin
                  r_line[r_cnt*BEAT_LEN +: BEAT_LEN] <= mem_rsp_data_i;
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == CW'(LINE_BEATS-1)) r_state <= S_WRITE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // All outputs come from state or registers only.
   assign miss_ready_o    = (r_state == S_IDLE);
   assign mem_req_valid_o = (r_state == S_REQ);
   assign mem_req_addr_o  = r_addr;
   assign line_we_o       = (r_state == S_WRITE);
   assign repl_update_o   = (r_state == S_WRITE);
   assign line_way_o      = r_way;
   assign line_addr_o     = r_addr;
   assign line_data_o     = r_line;
   assign onehot_err_o    = r_err;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: a 2-way and a 4-way instance share the
// memory side; each is driven through its own miss port.
module tb_icache_refill_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0]  miss_addr = '0;
   logic         req_ready = 1'b0;
   logic         rsp_valid = 1'b0;
   logic [63:0]  rsp_data  = '0;

   logic         mv2 = 1'b0, mv4 = 1'b0;
   logic [1:0]   vic2 = '0;
   logic [3:0]   vic4 = '0;

   logic         rdy2, rqv2, we2, rep2, err2;
   logic [31:0]  rqa2, la2;
   logic [0:0]   way2;
   logic [255:0] ld2;
   logic         rdy4, rqv4, we4, rep4, err4;
   logic [31:0]  rqa4, la4;
   logic [1:0]   way4;
   logic [255:0] ld4;

   icache_refill_ctrl #(.N_WAYS(2)) u2 (
      .clk_i(clk), .rst_ni(rst_n), .miss_valid_i(mv2), .miss_ready_o(rdy2),
      .miss_addr_i(miss_addr), .victim_oh_i(vic2), .mem_req_valid_o(rqv2),
      .mem_req_ready_i(req_ready), .mem_req_addr_o(rqa2), .mem_rsp_valid_i(rsp_valid),
      .mem_rsp_data_i(rsp_data), .line_we_o(we2), .line_way_o(way2), .line_addr_o(la2),
      .line_data_o(ld2), .repl_update_o(rep2), .onehot_err_o(err2));

   icache_refill_ctrl #(.N_WAYS(4)) u4 (
      .clk_i(clk), .rst_ni(rst_n), .miss_valid_i(mv4), .miss_ready_o(rdy4),
      .miss_addr_i(miss_addr), .victim_oh_i(vic4), .mem_req_valid_o(rqv4),
      .mem_req_ready_i(req_ready), .mem_req_addr_o(rqa4), .mem_rsp_valid_i(rsp_valid),
      .mem_rsp_data_i(rsp_data), .line_we_o(we4), .line_way_o(way4), .line_addr_o(la4),
      .line_data_o(ld4), .repl_update_o(rep4), .onehot_err_o(err4));

   int total = 0;
   int bad   = 0;
   int we2_n = 0, we4_n = 0;

   always @(posedge clk) begin
      if (we2) we2_n++;
      if (we4) we4_n++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] mkline(input logic [7:0] base);
      logic [255:0] l;
      for (int k = 0; k < 4; k++) l[k*64 +: 64] = 64'(base + 8'(k));
      return l;
   endfunction

   // Zero-wait refill on the 4-way instance, checks the write cycle and re-ready.
   task automatic refill4(input logic [3:0] v, input logic [31:0] a, input logic [7:0] base,
                          input logic [1:0] exp_way, input logic exp_err);
      int n0;
      n0 = we4_n;
      miss_addr = a; vic4 = v; mv4 = 1'b1; req_ready = 1'b1;
      tick();
      mv4 = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) begin
         rsp_valid = 1'b1; rsp_data = 64'(base + 8'(k));
         tick();
      end
      rsp_valid = 1'b0;
      chk("r4_we",   {255'd0, we4}, 256'd1);
      chk("r4_way",  {254'd0, way4}, {254'd0, exp_way});
      chk("r4_err",  {255'd0, err4}, {255'd0, exp_err});
      chk("r4_addr", {224'd0, la4}, {224'd0, a & 32'hFFFF_FFE0});
      chk("r4_data", ld4, mkline(base));
      tick();
      chk("r4_rdy",  {255'd0, rdy4}, 256'd1);
      chk("r4_wecnt", 256'(we4_n - n0), 256'd1);
   endtask

   initial begin
      // reset state
      tick(); tick();
      chk("rst_rdy",  {255'd0, rdy2}, 256'd1);
      chk("rst_rqv",  {255'd0, rqv2}, 256'd0);
      chk("rst_we",   {254'd0, we2, rep2}, 256'd0);
      chk("rst_err",  {254'd0, err2, err4}, 256'd0);
      chk("rst_data", ld2 | ld4, 256'd0);
      chk("rst_addr", {192'd0, rqa2, la4}, 256'd0);
      chk("rst_way",  {253'd0, way2, way4}, 256'd0);
      rst_n = 1'b1;
      tick();

      // basic refill on the 2-way instance; a beat in the handshake cycle is ignored
      miss_addr = 32'h0000_1234; vic2 = 2'b10; mv2 = 1'b1; req_ready = 1'b1;
      tick();
      mv2 = 1'b0;
      chk("b_rdy",  {255'd0, rdy2}, 256'd0);
      chk("b_rqv",  {255'd0, rqv2}, 256'd1);
      chk("b_rqa",  {224'd0, rqa2}, 256'h1220);
      rsp_valid = 1'b1; rsp_data = 64'hEE;
      tick();
      for (int k = 0; k < 4; k++) begin
         chk("b_nowe", {255'd0, we2}, 256'd0);
         rsp_valid = 1'b1; rsp_data = 64'hA0 + 64'(k);
         tick();
      end
      rsp_valid = 1'b0;
      chk("b_we",   {254'd0, we2, rep2}, 256'd3);
      chk("b_way",  {255'd0, way2}, 256'd1);
      chk("b_addr", {224'd0, la2}, 256'h1220);
      chk("b_data", ld2, {64'hA3, 64'hA2, 64'hA1, 64'hA0});
      tick();
      chk("b_off",  {254'd0, we2, rep2}, 256'd0);
      chk("b_rdy2", {255'd0, rdy2}, 256'd1);

      // stray response beats in idle
      rsp_valid = 1'b1; rsp_data = 64'hFF;
      tick(); tick();
      rsp_valid = 1'b0;
      chk("s_rdy",  {255'd0, rdy2}, 256'd1);
      chk("s_data", ld2, {64'hA3, 64'hA2, 64'hA1, 64'hA0});
      chk("s_wecnt", 256'(we2_n), 256'd1);

      // backpressure, gapped beats, ignored miss during RECV (4-way)
      miss_addr = 32'h0000_ABCD; vic4 = 4'b0001; mv4 = 1'b1; req_ready = 1'b0;
      tick();
      mv4 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("bp_rqv", {255'd0, rqv4}, 256'd1);
         chk("bp_rqa", {224'd0, rqa4}, 256'hABC0);
         tick();
      end
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      chk("bp_rqv0", {255'd0, rqv4}, 256'd0);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin
            rsp_valid = 1'b0;
            if (k == 2) begin
               mv4 = 1'b1; vic4 = 4'b1000; miss_addr = 32'h0000_7700;
            end
            tick();
            mv4 = 1'b0;
            chk("bp_nowe", {255'd0, we4}, 256'd0);
            chk("bp_rdy",  {255'd0, rdy4}, 256'd0);
         end
         rsp_valid = 1'b1; rsp_data = 64'hB0 + 64'(k);
         tick();
      end
      rsp_valid = 1'b0;
      chk("bp_we",   {255'd0, we4}, 256'd1);
      chk("bp_way",  {254'd0, way4}, 256'd0);
      chk("bp_addr", {224'd0, la4}, 256'hABC0);
      chk("bp_data", ld4, mkline(8'hB0));
      tick();
      chk("bp_wecnt", 256'(we4_n), 256'd1);

      // way encoding and bad pointer
      refill4(4'b0010, 32'h0000_2000, 8'h10, 2'd1, 1'b0);
      refill4(4'b0100, 32'h0000_3011, 8'h20, 2'd2, 1'b0);
      refill4(4'b1000, 32'h0000_403F, 8'h30, 2'd3, 1'b0);
      refill4(4'b0110, 32'h0000_5008, 8'h40, 2'd1, 1'b1);
      refill4(4'b0001, 32'h0000_6000, 8'h50, 2'd0, 1'b1);

      // reset mid-RECV after two beats
      miss_addr = 32'h0000_0040; vic2 = 2'b01; mv2 = 1'b1; req_ready = 1'b1;
      tick();
      mv2 = 1'b0;
      tick();
      rsp_valid = 1'b1; rsp_data = 64'hD0; tick();
      rsp_data = 64'hD1; tick();
      rsp_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mr_rdy",  {255'd0, rdy2}, 256'd1);
      chk("mr_out",  {253'd0, rqv2, we2, rep2}, 256'd0);
      chk("mr_data", ld2, 256'd0);
      chk("mr_addr", {192'd0, rqa2, la2}, 256'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("mr_wecnt", 256'(we2_n), 256'd1);

      // next miss after reset refills correctly
      miss_addr = 32'h1000_0047; vic2 = 2'b01; mv2 = 1'b1;
      tick();
      mv2 = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) begin
         rsp_valid = 1'b1; rsp_data = 64'hC0 + 64'(k);
         tick();
      end
      rsp_valid = 1'b0;
      chk("ar_we",   {254'd0, we2, rep2}, 256'd3);
      chk("ar_way",  {255'd0, way2}, 256'd0);
      chk("ar_addr", {224'd0, la2}, 256'h1000_0040);
      chk("ar_data", ld2, mkline(8'hC0));
      tick();
      chk("ar_wecnt", 256'(we2_n), 256'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
